// File: rtl/cfg_link_if.sv
`default_nettype none
// ============================================================================
// Module   : cfg_link_if
// Purpose  : Request/data/ack/done handshakes of the two frame writers plus
//            the serial configuration link outputs of cfg_link_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface cfg_link_if #(
    parameter int SIZESRSTAT = 88,
    parameter int SIZESRDYN  = 16
);
    logic                  link_en;
    logic                  dyn_req;
    logic [SIZESRDYN-1:0]  dyn_data;
    logic                  dyn_ack;
    logic                  dyn_done;
    logic                  stat_req;
    logic [SIZESRSTAT-1:0] stat_data;
    logic                  stat_ack;
    logic                  stat_done;
    logic                  sclk;
    logic                  sel;
    logic                  mosi;
    logic                  frame_stat;
    logic                  busy;

    // Requester side: drives requests and frame data, observes the link.
    modport master (
        output link_en, dyn_req, dyn_data, stat_req, stat_data,
        input  dyn_ack, dyn_done, stat_ack, stat_done,
        input  sclk, sel, mosi, frame_stat, busy
    );

    // Scheduler side.
    modport slave (
        input  link_en, dyn_req, dyn_data, stat_req, stat_data,
        output dyn_ack, dyn_done, stat_ack, stat_done,
        output sclk, sel, mosi, frame_stat, busy
    );
endinterface
`default_nettype wire

// File: rtl/cfg_link_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : cfg_link_scheduler
// Purpose  : Round-robin sharing of the serial config link (sclk/sel/mosi)
//            between the dynamic and static register writers. Captures the
//            granted frame, shifts it out MSB-first on a divided clock and
//            reports completion with a done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module cfg_link_scheduler #(
    parameter int SIZESRSTAT = 88,
    parameter int SIZESRDYN  = 16,
    parameter int CLK_DIV    = 8,
    parameter int GAP_CYCLES = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    cfg_link_if.slave   bus
);
    localparam int H       = CLK_DIV / 2;
    localparam int SR_W    = (SIZESRSTAT > SIZESRDYN) ? SIZESRSTAT : SIZESRDYN;
    localparam int CNT_MAX = (H > GAP_CYCLES) ? H : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(SR_W + 1);

    localparam logic [CNT_W-1:0] C_HALF = CNT_W'(H);
    localparam logic [CNT_W-1:0] C_GAP  = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [BIT_W-1:0] C_LAST_STAT = BIT_W'(SIZESRSTAT - 1);
    localparam logic [BIT_W-1:0] C_LAST_DYN  = BIT_W'(SIZESRDYN - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t             state;
    logic [SR_W-1:0]    shreg;
    logic [CNT_W-1:0]   cnt;
    logic [BIT_W-1:0]   bit_idx;
    logic [BIT_W-1:0]   last_bit;
    logic               last_grant;     // 1 = static writer was served last
    logic               grant_stat;

    // Static wins if it is the only requester, or if dynamic was served last.
    assign grant_stat = bus.stat_req && (!bus.dyn_req || !last_grant);

    // Arbitration, frame capture and link serialisation with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            shreg          <= '0;
            cnt            <= '0;
            bit_idx        <= '0;
            last_bit       <= '0;
            last_grant     <= 1'b1;
            bus.sclk       <= 1'b0;
            bus.sel        <= 1'b0;
            bus.mosi       <= 1'b0;
            bus.frame_stat <= 1'b0;
            bus.busy       <= 1'b0;
            bus.dyn_ack    <= 1'b0;
            bus.stat_ack   <= 1'b0;
            bus.dyn_done   <= 1'b0;
            bus.stat_done  <= 1'b0;
        end else begin
            bus.dyn_ack   <= 1'b0;
            bus.stat_ack  <= 1'b0;
            bus.dyn_done  <= 1'b0;
            bus.stat_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.link_en && (bus.dyn_req || bus.stat_req)) begin
                        state    <= SETUP;
                        bus.busy <= 1'b1;
                        cnt      <= '0;
                        bit_idx  <= '0;
                        if (grant_stat) begin
                            bus.stat_ack   <= 1'b1;
                            bus.frame_stat <= 1'b1;
                            last_grant     <= 1'b1;
                            last_bit       <= C_LAST_STAT;
                            shreg          <= SR_W'(bus.stat_data) << (SR_W - SIZESRSTAT);
                        end else begin
                            bus.dyn_ack    <= 1'b1;
                            bus.frame_stat <= 1'b0;
                            last_grant     <= 1'b0;
                            last_bit       <= C_LAST_DYN;
                            shreg          <= SR_W'(bus.dyn_data) << (SR_W - SIZESRDYN);
                        end
                    end
                end
                // sel rises one cycle after the grant; MSB sits on mosi for H
                // cycles of sclk low before the first rising edge.
                SETUP: begin
                    bus.sel  <= 1'b1;
                    bus.mosi <= shreg[SR_W-1];
                    if (cnt == C_HALF) begin
                        bus.sclk <= 1'b1;
                        cnt      <= C_ONE;
                        state    <= SHIFT;
                    end else begin
                        cnt <= cnt + C_ONE;
                    end
                end
                // Each half phase lasts H cycles; data advances on the falling
                // edge so it is centred on the next rising edge.
                SHIFT: begin
                    if (cnt == C_HALF) begin
                        cnt <= C_ONE;
                        if (bus.sclk) begin
                            bus.sclk <= 1'b0;
                            if (bit_idx != last_bit) begin
                                shreg    <= shreg << 1;
                                bus.mosi <= shreg[SR_W-2];
                            end
                        end else if (bit_idx == last_bit) begin
                            state <= HOLD;
                        end else begin
                            bus.sclk <= 1'b1;
                            bit_idx  <= bit_idx + BIT_W'(1);
                        end
                    end else begin
                        cnt <= cnt + C_ONE;
                    end
                end
                // Keep the last bit and sel for H cycles, then release the
                // link; the done pulse coincides with sel reading low.
                HOLD: begin
                    if (cnt == C_HALF) begin
                        bus.sel        <= 1'b0;
                        bus.mosi       <= 1'b0;
                        bus.frame_stat <= 1'b0;
                        bus.stat_done  <= bus.frame_stat;
                        bus.dyn_done   <= !bus.frame_stat;
                        cnt            <= C_ONE;
                        state          <= GAP;
                    end else begin
                        cnt <= cnt + C_ONE;
                    end
                end
                GAP: begin
                    if (cnt == C_GAP) begin
                        bus.busy <= 1'b0;
                        cnt      <= '0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + C_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
